// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and word-select helper for the L1 data cache.
package dcache_pkg;

  localparam int unsigned OFFSET_W       = 5;
  localparam int unsigned LINE_BITS      = 256;
  localparam int unsigned WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } state_e;

  // Word index within a line; byte-lane bits [1:0] are dropped by the shift.
  function automatic logic [2:0] word_sel(input logic [31:0] addr);
    return 3'((addr >> 2) & 32'h7);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/dirty/data storage: one combinational read port,
// synchronous line fill and single-word merge on the same index.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES     = 32,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned INDEX_W   = 5,
  parameter int unsigned TAG_W     = 22
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INDEX_W-1:0]   idx_i,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic                 rd_valid_o,
  output logic                 rd_dirty_o,
  output logic [LINE_BITS-1:0] rd_line_o,
  input  logic                 fill_en_i,
  input  logic [TAG_W-1:0]     fill_tag_i,
  input  logic [LINE_BITS-1:0] fill_line_i,
  input  logic                 merge_en_i,
  input  logic [2:0]           merge_word_i,
  input  logic [31:0]          merge_data_i
);

  localparam int unsigned WORD_W = LINE_BITS / WORDS_PER_LINE;

  logic [LINE_BITS-1:0] data_arr [LINES];
  logic [TAG_W-1:0]     tag_arr  [LINES];
  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;

  assign rd_tag_o   = tag_arr[idx_i];
  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_line_o  = data_arr[idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (merge_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data are not reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill_en_i) begin
        tag_arr[idx_i]  <= fill_tag_i;
        data_arr[idx_i] <= fill_line_i;
      end else if (merge_en_i) begin
        data_arr[idx_i][int'(merge_word_i) * WORD_W +: WORD_W] <= merge_data_i[WORD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// L1 data-cache controller: direct-mapped, write-back, write-allocate, with a
// req/ack line port to memory and a combinational pipeline stall.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES     = 32,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = 32 - INDEX_W - OFFSET_W;

  state_e state_q, state_d;

  logic [INDEX_W-1:0]   cpu_idx, look_idx, m_idx_q;
  logic [TAG_W-1:0]     cpu_tag, m_tag_q;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_valid, rd_dirty, hit;
  logic [LINE_BITS-1:0] rd_line;
  logic                 fill_en, merge_en, miss;
  logic [2:0]           word;

  assign cpu_idx = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign cpu_tag = cpu_addr_i[31 -: TAG_W];
  assign word    = word_sel(cpu_addr_i);

  // The miss address is latched so a dropped request still installs its line.
  assign look_idx = (state_q == ST_IDLE) ? cpu_idx : m_idx_q;

  dcache_array #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .idx_i        (look_idx),
    .rd_tag_o     (rd_tag),
    .rd_valid_o   (rd_valid),
    .rd_dirty_o   (rd_dirty),
    .rd_line_o    (rd_line),
    .fill_en_i    (fill_en),
    .fill_tag_i   (m_tag_q),
    .fill_line_i  (mem_data_i),
    .merge_en_i   (merge_en),
    .merge_word_i (word),
    .merge_data_i (cpu_data_i)
  );

  assign hit         = rd_valid & (rd_tag == cpu_tag);
  assign cpu_stall_o = cpu_req_i & (~hit | (state_q != ST_IDLE));
  assign cpu_data_o  = cpu_req_i ? rd_line[int'(word) * 32 +: 32] : '0;

  assign miss     = (state_q == ST_IDLE) & cpu_req_i & ~hit;
  assign merge_en = (state_q == ST_IDLE) & cpu_req_i & cpu_write_i & hit & ~rst_i;
  assign fill_en  = (state_q == ST_REFILL) & mem_ack_i & ~rst_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (miss) state_d = (rd_valid & rd_dirty) ? ST_WRITEBACK : ST_REFILL;
      ST_WRITEBACK: if (mem_ack_i) state_d = ST_REFILL;
      ST_REFILL:    if (mem_ack_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      m_idx_q <= '0;
      m_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss) begin
        m_idx_q <= cpu_idx;
        m_tag_q <= cpu_tag;
      end
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    case (state_q)
      ST_WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {rd_tag, m_idx_q, {OFFSET_W{1'b0}}};
        mem_data_o  = rd_line;
      end
      ST_REFILL: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = {m_tag_q, m_idx_q, {OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a hand-driven memory port.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_ack_i;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cyc = 0;
  int mreq_cyc  = 0;
  int wb_cyc    = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(32), .LINE_BITS(256)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_write_i (cpu_write_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  always @(negedge clk) begin
    if (cpu_stall_o) stall_cyc++;
    if (mem_req_o) mreq_cyc++;
    if (mem_req_o && mem_write_o) wb_cyc++;
  end

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Ack on the d-th cycle of the current transaction (cycle 1 is the present one).
  task automatic serve(input int d, input logic [255:0] ln);
    for (int i = 1; i < d; i++) step();
    mem_ack_i  = 1'b1;
    mem_data_i = ln;
    step();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic cpu(input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_req_i   = req;
    cpu_write_i = wr;
    cpu_addr_i  = a;
    cpu_data_i  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] line1, line2, line3, line4, wb;
    int s0, m0, w0;

    line1 = mk_line(32'h1000_0000);
    line1[31:0]  = 32'hDEAD_BEEF;
    line1[95:64] = 32'hDEAD_BEEF;
    line2 = mk_line(32'h2000_0000);
    line3 = mk_line(32'h3000_0000);
    line4 = mk_line(32'h4000_0000);

    rst_i = 1'b1; mem_ack_i = 1'b0; mem_data_i = '0;
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step(); step();
    rst_i = 1'b0;
    settle();
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_write", mem_write_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_data", mem_data_o, 0);
    check("rst_stall_idle", cpu_stall_o, 0);
    check("rst_data_idle", cpu_data_o, 0);

    // Cold load: 10-cycle refill, 11 stall cycles.
    cpu(1'b1, 1'b0, 32'h40, 32'h0);
    settle();
    check("cold_stall", cpu_stall_o, 1);
    check("cold_idle_noreq", mem_req_o, 0);
    s0 = stall_cyc; m0 = mreq_cyc;
    step();
    check("cold_req", mem_req_o, 1);
    check("cold_write", mem_write_o, 0);
    check("cold_addr", mem_addr_o, 32'h40);
    serve(10, line1);
    settle();
    check("cold_stall_drop", cpu_stall_o, 0);
    check("cold_data", cpu_data_o, 32'hDEAD_BEEF);
    check("cold_req_done", mem_req_o, 0);
    check("cold_stall_cycles", stall_cyc - s0, 11);
    check("cold_req_cycles", mreq_cyc - m0, 10);

    cpu(1'b1, 1'b0, 32'h48, 32'h0);
    settle();
    check("hit48_stall", cpu_stall_o, 0);
    check("hit48_data", cpu_data_o, 32'hDEAD_BEEF);
    cpu(1'b1, 1'b0, 32'h4C, 32'h0);
    settle();
    check("hit4c_data", cpu_data_o, 32'h1000_0003);

    // Store hit then load back with no memory traffic.
    m0 = mreq_cyc;
    cpu(1'b1, 1'b1, 32'h44, 32'h1234_5678);
    settle();
    check("st44_stall", cpu_stall_o, 0);
    step();
    cpu(1'b1, 1'b0, 32'h44, 32'h0);
    settle();
    check("ld44_stall", cpu_stall_o, 0);
    check("ld44_data", cpu_data_o, 32'h1234_5678);
    step();
    check("ld44_no_traffic", mreq_cyc - m0, 0);

    // Conflict load with dirty victim: writeback then refill.
    cpu(1'b1, 1'b0, 32'h440, 32'h0);
    settle();
    check("conf_stall", cpu_stall_o, 1);
    s0 = stall_cyc;
    step();
    wb = mem_data_o;
    check("wb_req", mem_req_o, 1);
    check("wb_write", mem_write_o, 1);
    check("wb_addr", mem_addr_o, 32'h40);
    check("wb_word1", wb[63:32], 32'h1234_5678);
    check("wb_word0", wb[31:0], 32'hDEAD_BEEF);
    serve(3, '0);
    settle();
    check("conf_refill_write", mem_write_o, 0);
    check("conf_refill_addr", mem_addr_o, 32'h440);
    serve(4, line2);
    settle();
    check("conf_stall_drop", cpu_stall_o, 0);
    check("conf_data", cpu_data_o, 32'h2000_0000);
    check("conf_stall_cycles", stall_cyc - s0, 8);

    // Store miss to a clean conflicting line: refill only, then merge.
    w0 = wb_cyc;
    cpu(1'b1, 1'b1, 32'h58, 32'hCAFE_F00D);
    settle();
    check("stm_stall", cpu_stall_o, 1);
    step();
    check("stm_write", mem_write_o, 0);
    check("stm_addr", mem_addr_o, 32'h40);
    serve(2, line1);
    settle();
    check("stm_stall_drop", cpu_stall_o, 0);
    step();
    cpu(1'b1, 1'b0, 32'h58, 32'h0);
    settle();
    check("stm_data", cpu_data_o, 32'hCAFE_F00D);
    check("stm_no_wb", wb_cyc - w0, 0);
    cpu(1'b1, 1'b0, 32'h440, 32'h0);
    settle();
    step();
    wb = mem_data_o;
    check("stm_dirty_wb", mem_write_o, 1);
    check("stm_dirty_addr", mem_addr_o, 32'h40);
    check("stm_dirty_word6", wb[223:192], 32'hCAFE_F00D);
    serve(1, '0);
    settle();
    check("stm_refill_addr", mem_addr_o, 32'h440);
    serve(1, line2);
    settle();
    check("stm_reload_data", cpu_data_o, 32'h2000_0000);

    // Reset during refill, then a late ack.
    cpu(1'b1, 1'b0, 32'h840, 32'h0);
    settle();
    step();
    check("rr_addr", mem_addr_o, 32'h840);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    cpu(1'b0, 1'b0, 32'h840, 32'h0);
    mem_ack_i = 1'b1; mem_data_i = line3;
    settle();
    check("rr_req_off", mem_req_o, 0);
    check("rr_stall_noreq", cpu_stall_o, 0);
    step();
    mem_ack_i = 1'b0; mem_data_i = '0;
    check("rr_ack_ignored", mem_req_o, 0);
    cpu(1'b1, 1'b0, 32'h840, 32'h0);
    settle();
    check("rr_remiss", cpu_stall_o, 1);
    step();
    check("rr_refill_req", mem_req_o, 1);
    check("rr_refill_addr", mem_addr_o, 32'h840);
    serve(1, line3);
    settle();
    check("rr_data", cpu_data_o, 32'h3000_0000);

    // Long ack delay: outputs must hold for 50 cycles.
    cpu(1'b1, 1'b0, 32'hC40, 32'h0);
    settle();
    step();
    for (int i = 0; i < 50; i++) begin
      check("hold_req", mem_req_o, 1);
      check("hold_write", mem_write_o, 0);
      check("hold_addr", mem_addr_o, 32'hC40);
      check("hold_stall", cpu_stall_o, 1);
      step();
    end
    serve(1, line4);
    settle();
    check("hold_done_stall", cpu_stall_o, 0);
    check("hold_done_data", cpu_data_o, 32'h4000_0000);
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("noreq_data_zero", cpu_data_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
